// File: rtl/lc3b_byte_mem_adapter_if.sv
// CPU 16-bit memory port and 8-bit physical memory port of the byte adapter.
// master = CPU/memory environment, slave = adapter.
interface lc3b_byte_mem_adapter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            mem_byte_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;
  logic                  mem_resp;
  logic                  busy;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [7:0]            pmem_wdata;
  logic [7:0]            pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, busy,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, busy,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/lc3b_byte_mem_adapter.sv
// Splits each LC-3b 16-bit word access into low/high byte accesses on an 8-bit memory.
// Latency 1 + bytes*(1+pmem waits) cycles; the pmem strobe is held until pmem_resp.
module lc3b_byte_mem_adapter #(
  parameter int ADDR_WIDTH = 16
) (
  input logic                    clk,
  input logic                    reset,
  lc3b_byte_mem_adapter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_ONE;

  state_t                state;
  state_t                state_nxt;
  logic                  op_read_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [1:0]            be_q;
  logic [15:0]           rdata_q;
  logic                  req;

  assign req           = bus.mem_read | bus.mem_write;
  assign bus.mem_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      // Read has priority when both requests are raised together.
      if (state == IDLE && req) begin
        op_read_q <= bus.mem_read;
        addr_q    <= bus.mem_address & WORD_MASK;
        wdata_q   <= bus.mem_wdata;
        be_q      <= bus.mem_byte_enable;
      end
      if (op_read_q && bus.pmem_resp) begin
        if (state == LO)
          rdata_q[7:0] <= bus.pmem_rdata;
        else if (state == HI)
          rdata_q[15:8] <= bus.pmem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.mem_resp     = 1'b0;
    bus.busy         = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.mem_read)
          state_nxt = LO;
        else if (bus.mem_write) begin
          if (bus.mem_byte_enable[0])
            state_nxt = LO;
          else if (bus.mem_byte_enable[1])
            state_nxt = HI;
          else
            state_nxt = DONE;
        end
      end
      LO: begin
        bus.pmem_read    = op_read_q;
        bus.pmem_write   = ~op_read_q;
        bus.pmem_address = addr_q;
        bus.pmem_wdata   = wdata_q[7:0];
        if (bus.pmem_resp)
          state_nxt = (op_read_q || be_q[1]) ? HI : DONE;
      end
      HI: begin
        bus.pmem_read    = op_read_q;
        bus.pmem_write   = ~op_read_q;
        bus.pmem_address = addr_q | ADDR_ONE;
        bus.pmem_wdata   = wdata_q[15:8];
        if (bus.pmem_resp)
          state_nxt = DONE;
      end
      DONE: begin
        bus.mem_resp = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3b_byte_mem_adapter.sv
// Randomized bench: byte-memory responder with programmable wait cycles plus a
// transaction-level model predicting byte accesses, latency and read data.
module tb_lc3b_byte_mem_adapter;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  dat;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  lc3b_byte_mem_adapter_if #(.ADDR_WIDTH(16)) b ();

  lc3b_byte_mem_adapter #(.ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [65536];
  acc_t        acc_log[$];
  int          wait_cfg = 0;
  bit          hold_resp = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          n_txn = 0;
  int          resp_count = 0;
  int          viol_resp = 0;
  int          viol_pmem = 0;
  int          since_resp = 100;
  logic [15:0] model_rdata = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Physical byte memory: answers after wait_cfg idle cycles, logs every completed access.
  initial begin
    int   cnt;
    acc_t a;
    cnt = 0;
    b.pmem_resp  = 1'b0;
    b.pmem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      b.pmem_resp = 1'b0;
      if (hold_resp || !(b.pmem_read || b.pmem_write))
        cnt = wait_cfg;
      else if (cnt > 0)
        cnt--;
      else begin
        b.pmem_resp = 1'b1;
        a.wr   = b.pmem_write;
        a.addr = b.pmem_address;
        if (b.pmem_write) begin
          mem[b.pmem_address] = b.pmem_wdata;
          a.dat = b.pmem_wdata;
        end else begin
          b.pmem_rdata = mem[b.pmem_address];
          a.dat = mem[b.pmem_address];
        end
        acc_log.push_back(a);
        cnt = wait_cfg;
      end
    end
  end

  // Protocol monitor: single-cycle responses, exclusive strobes, quiet pmem port when idle.
  always @(negedge clk) begin
    if (!reset) begin
      if (b.mem_resp) begin
        if (since_resp == 0) viol_resp++;
        resp_count++;
        since_resp = 0;
      end else begin
        since_resp++;
      end
      if (b.pmem_read && b.pmem_write) viol_pmem++;
      if ((!b.busy || b.mem_resp) &&
          (b.pmem_read || b.pmem_write || b.pmem_address != 16'h0 || b.pmem_wdata != 8'h0))
        viol_pmem++;
    end
  end

  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] be,
                         input int waits, input bit keep);
    logic [15:0] word;
    logic [15:0] hi_addr;
    acc_t        exp_q[$];
    int          exp_lat;
    int          cyc;
    int          n;
    bit          done;
    word    = {addr[15:1], 1'b0};
    hi_addr = word + 16'h1;
    if (rd) begin
      exp_q.push_back('{1'b0, word, mem[word]});
      exp_q.push_back('{1'b0, hi_addr, mem[hi_addr]});
      model_rdata = {mem[hi_addr], mem[word]};
    end else if (wr) begin
      if (be[0]) exp_q.push_back('{1'b1, word, wd[7:0]});
      if (be[1]) exp_q.push_back('{1'b1, hi_addr, wd[15:8]});
    end
    exp_lat  = 1 + exp_q.size() * (1 + waits);
    wait_cfg = waits;
    acc_log.delete();

    @(negedge clk);
    b.mem_read        = rd;
    b.mem_write       = wr;
    b.mem_address     = addr;
    b.mem_wdata       = wd;
    b.mem_byte_enable = be;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (b.mem_resp)
        done = 1'b1;
      else begin
        b.mem_address     = 16'($urandom);
        b.mem_wdata       = 16'($urandom);
        b.mem_byte_enable = 2'($urandom);
      end
    end
    chk("resp_latency", cyc, exp_lat);

    @(posedge clk);
    #1;
    chk("resp_one_cycle", b.mem_resp, 1'b0);
    chk("busy_idle", b.busy, 1'b0);
    chk("mem_rdata", b.mem_rdata, model_rdata);
    chk("n_accesses", acc_log.size(), exp_q.size());
    n = (acc_log.size() < exp_q.size()) ? acc_log.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk("access", acc_log[i], exp_q[i]);
    if (!keep) begin
      b.mem_read  = 1'b0;
      b.mem_write = 1'b0;
    end
    n_txn++;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    b.mem_read        = 1'b0;
    b.mem_write       = 1'b0;
    b.mem_byte_enable = 2'b00;
    b.mem_address     = 16'h0000;
    b.mem_wdata       = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", b.busy, 1'b0);
    chk("rst_resp", b.mem_resp, 1'b0);
    chk("rst_rdata", b.mem_rdata, 16'h0000);
    chk("rst_strobes", {b.pmem_read, b.pmem_write}, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    mem[16'h3002] = 8'hCD;
    mem[16'h3003] = 8'hAB;
    run_txn(1'b1, 1'b0, 16'h3002, 16'h0000, 2'b00, 0, 1'b0);
    chk("read_abcd", b.mem_rdata, 16'hABCD);

    run_txn(1'b0, 1'b1, 16'h4001, 16'h1234, 2'b11, 2, 1'b0);
    chk("full_write_mem", {mem[16'h4001], mem[16'h4000]}, 16'h1234);
    chk("rdata_held", b.mem_rdata, 16'hABCD);

    run_txn(1'b0, 1'b1, 16'h5000, 16'hBEEF, 2'b10, 0, 1'b0);
    run_txn(1'b0, 1'b1, 16'h5000, 16'hCAFE, 2'b01, 0, 1'b0);
    run_txn(1'b0, 1'b1, 16'h5000, 16'h9999, 2'b00, 0, 1'b0);
    chk("partial_mem", {mem[16'h5001], mem[16'h5000]}, 16'hBEFE);

    run_txn(1'b1, 1'b1, 16'h6000, 16'h7777, 2'b11, 1, 1'b0);

    // Abort a read while its high byte is stalled.
    mem[16'h7010] = 8'h5A;
    mem[16'hFFFE] = 8'h11;
    mem[16'hFFFF] = 8'h22;
    wait_cfg = 1;
    @(negedge clk);
    b.mem_read    = 1'b1;
    b.mem_address = 16'h7010;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (b.pmem_read && b.pmem_address[0]) found = 1'b1;
    end
    hold_resp = 1'b1;
    chk("reached_hi", found, 1'b1);
    b.mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", b.busy, 1'b0);
    chk("abort_strobes", {b.pmem_read, b.pmem_write}, 2'b00);
    chk("abort_rdata", b.mem_rdata, 16'h0000);
    chk("abort_resp", b.mem_resp, 1'b0);
    reset       = 1'b0;
    hold_resp   = 1'b0;
    model_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    run_txn(1'b1, 1'b0, 16'hFFFE, 16'h0000, 2'b00, 0, 1'b0);
    chk("wrap_read", b.mem_rdata, 16'h2211);

    run_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 0, 1'b1);
    run_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int   kind;
      bit   rd;
      bit   wr;
      kind = $urandom_range(2, 0);
      rd   = (kind != 1);
      wr   = (kind != 0);
      run_txn(rd, wr, 16'($urandom), 16'($urandom), 2'($urandom),
              $urandom_range(3, 0), (t != 39) && ($urandom_range(3, 0) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("resp_pulses", resp_count, n_txn);
    chk("resp_spacing", viol_resp, 0);
    chk("pmem_protocol", viol_pmem, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_byte_mem_adapter.md
Name: lc3b_byte_mem_adapter

Overview:
- Bridges the LC-3b CPU 16-bit memory port to an 8-bit physical memory.
- CPU-side signals are mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, mem_rdata and mem_resp, driven by or consumed by the control FSM and datapath.
- Each CPU word access is split into sequenced byte accesses on the pmem_* port. Exactly one mem_resp pulse is returned per CPU transaction.

Parameters:
- ADDR_WIDTH, 16, width of mem_address and pmem_address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  2  write byte mask; bit0 = low byte, bit1 = high byte.
- mem_address  in  ADDR_WIDTH  CPU byte address; bit0 ignored (word aligned).
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data; registered.
- mem_resp  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- pmem_read  out  1  physical byte read strobe.
- pmem_write  out  1  physical byte write strobe.
- pmem_address  out  ADDR_WIDTH  physical byte address.
- pmem_wdata  out  8  physical write byte.
- pmem_rdata  in  8  physical read byte; valid when pmem_resp = 1.
- pmem_resp  in  1  physical access complete (any latency ≥ 0 wait cycles).

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values: state = IDLE; mem_resp = 0; mem_rdata = 16'h0000; latched request registers = 0.
  - pmem_read, pmem_write and busy are 0 in the cycle after the reset edge.
  - Reset asserted mid-transaction aborts it: no mem_resp, pmem strobes drop, partial read data is discarded.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - Samples mem_read / mem_write.
  - If either is high: latch op, word address {mem_address[ADDR_WIDTH-1:1],1'b0}, mem_wdata and mem_byte_enable.
  - If mem_read and mem_write are both high, read wins and the write is ignored.
  - Next state on a request:
    - Reads always go to LO.
    - Writes go to LO if be[0], else HI if be[1], else DONE (be = 00: no pmem access).
- LO:
  - pmem address = word address; pmem_read or pmem_write asserted per latched op; pmem_wdata = wdata[7:0].
  - On pmem_resp: reads capture pmem_rdata into mem_rdata[7:0].
  - Next state after pmem_resp: reads go to HI; writes go to HI if be[1], else DONE.
  - Without pmem_resp: stay in LO with strobe held.
- HI:
  - pmem address = word address | 1; pmem_wdata = wdata[15:8].
  - On pmem_resp: reads capture into mem_rdata[15:8]; go to DONE.
- DONE: mem_resp = 1 for exactly one cycle; pmem strobes 0; next state is IDLE unconditionally.
- pmem_* outputs:
  - Combinational from state and latched registers.
  - pmem_read and pmem_write are never high together.
  - Both are 0 in IDLE and DONE.
  - pmem_address and pmem_wdata are 0 in IDLE and DONE.
- CPU-side inputs are ignored outside IDLE; changes mid-transaction have no effect.
- The requester deasserts its request in the cycle after mem_resp. A request still high in IDLE after DONE starts a new transaction.
- Latency: request first seen in IDLE at cycle 0, zero-wait pmem:
  - Read: LO at cycle 1, HI at cycle 2, mem_resp at cycle 3.
  - Full write: mem_resp at cycle 3.
  - Single-byte write: mem_resp at cycle 2.
  - be = 00 write: mem_resp at cycle 1.
  - Each pmem wait cycle adds one cycle.
- mem_rdata is updated only by read byte captures and holds its value across writes and idle cycles.
- Address wrap: word address 16'hFFFE accesses bytes 16'hFFFE and 16'hFFFF; no carry beyond bit0.

Test Plan:
- Read, zero-wait: mem_address = 16'h3002, memory [3002] = 8'hCD, [3003] = 8'hAB -> pmem_read at 3002 then 3003; mem_rdata = 16'hABCD; mem_resp pulse exactly 3 cycles after the request.
- Full write, 2 wait cycles per byte: addr 16'h4001, wdata 16'h1234, be 11 -> pmem_write at 4000 (wdata 34) then 4001 (wdata 12); mem_resp at cycle 7; mem_rdata unchanged.
- Partial writes:
  - be = 10 at 16'h5000 -> only one pmem_write, at 5001 with data wdata[15:8]; mem_resp at cycle 2.
  - be = 01 -> only one pmem_write, at 5000.
  - be = 00 -> no pmem strobe; mem_resp at cycle 1.
- Simultaneous mem_read = mem_write = 1 at 16'h6000 -> read performed, no pmem_write ever asserted, one mem_resp.
- Reset mid-read: assert reset while in HI with pmem_resp held low -> next cycle busy = 0, strobes 0, mem_rdata = 0, no mem_resp. A following read of 16'hFFFE completes normally at bytes FFFE and FFFF.
- Back-to-back: read held one cycle after mem_resp -> second transaction starts from IDLE. mem_resp pulses are separated by at least one IDLE cycle and never last more than 1 cycle.
